// File: rtl/boa_csr_file.sv
// Machine-mode CSR file for the Boa32 core.
// Answers the CSR access bus with zero-latency decode and read data.
// Applies CPU writes, trap entry and MRET on the clock edge.
// Holds the 64-bit cycle and retired-instruction counters.
module boa_csr_file #(
    parameter logic [31:0] hartid   = 32'd0,
    parameter logic [31:0] misa_val = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_wmode,
    input  logic [31:0] csr_wmask,
    output logic        csr_exists,
    output logic        csr_rdonly,
    output logic [1:0]  csr_priv,
    output logic [31:0] csr_rdata,
    input  logic        ex_trap,
    input  logic        ex_irq,
    input  logic        ex_priv,
    input  logic [30:0] ex_epc,
    input  logic [3:0]  ex_cause,
    output logic [30:0] ex_tvec,
    input  logic        ret,
    input  logic        ret_priv,
    output logic [30:0] ret_epc,
    input  logic        instret,
    output logic        mie_out
);

    // Architectural state; only the implemented bits are stored
    logic        r_mie;
    logic        r_mpie;
    logic [29:0] r_mtvec_base;
    logic        r_mtvec_mode;
    logic [31:0] r_mscratch;
    logic [30:0] r_mepc;
    logic        r_mcause_irq;
    logic [3:0]  r_mcause_code;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic        w_exists;
    logic [31:0] w_rdata;
    logic        w_rdonly;
    logic [31:0] w_wdata;
    logic        w_wen;
    logic        w_take_trap;
    logic        w_take_ret;
    logic [31:0] w_tvec_base;
    logic [31:0] w_tvec_full;

    logic w_wr_mstatus;
    logic w_wr_mtvec;
    logic w_wr_mscratch;
    logic w_wr_mepc;
    logic w_wr_mcause;
    logic w_wr_mcycle_lo;
    logic w_wr_mcycle_hi;
    logic w_wr_minstret_lo;
    logic w_wr_minstret_hi;

    // Address decode and read mux from current state
    always_comb begin
        w_exists = 1'b1;
        w_rdata  = '0;
        case (csr_addr)
            12'h300: w_rdata = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
            12'h301: w_rdata = misa_val;
            12'h305: w_rdata = {r_mtvec_base, 1'b0, r_mtvec_mode};
            12'h340: w_rdata = r_mscratch;
            12'h341: w_rdata = {r_mepc, 1'b0};
            12'h342: w_rdata = {r_mcause_irq, 27'b0, r_mcause_code};
            12'hF14: w_rdata = hartid;
            12'hB00, 12'hC00: w_rdata = r_mcycle[31:0];
            12'hB80, 12'hC80: w_rdata = r_mcycle[63:32];
            12'hB02, 12'hC02: w_rdata = r_minstret[31:0];
            12'hB82, 12'hC82: w_rdata = r_minstret[63:32];
            default: w_exists = 1'b0;
        endcase
    end

    assign csr_exists = w_exists;
    assign csr_rdata  = w_rdata;
    assign w_rdonly   = (csr_addr[11:10] == 2'b11);
    assign csr_rdonly = w_rdonly;
    assign csr_priv   = csr_addr[9:8];

    // Write data formed from the current read value and the operand
    always_comb begin
        w_wdata = w_rdata;
        case (csr_wmode)
            2'b01:   w_wdata = csr_wmask;
            2'b10:   w_wdata = w_rdata | csr_wmask;
            2'b11:   w_wdata = w_rdata & ~csr_wmask;
            default: w_wdata = w_rdata;
        endcase
    end

    assign w_wen       = csr_we && (csr_wmode != 2'b00) && w_exists && !w_rdonly;
    assign w_take_trap = (ex_trap || ex_irq) && ex_priv;
    assign w_take_ret  = ret && ret_priv && !w_take_trap;

    assign w_wr_mstatus     = w_wen && (csr_addr == 12'h300);
    assign w_wr_mtvec       = w_wen && (csr_addr == 12'h305);
    assign w_wr_mscratch    = w_wen && (csr_addr == 12'h340);
    assign w_wr_mepc        = w_wen && (csr_addr == 12'h341);
    assign w_wr_mcause      = w_wen && (csr_addr == 12'h342);
    assign w_wr_mcycle_lo   = w_wen && (csr_addr == 12'hB00);
    assign w_wr_mcycle_hi   = w_wen && (csr_addr == 12'hB80);
    assign w_wr_minstret_lo = w_wen && (csr_addr == 12'hB02);
    assign w_wr_minstret_hi = w_wen && (csr_addr == 12'hB82);

    // Handler address; vectored mode offsets interrupts only
    assign w_tvec_base = {r_mtvec_base, 2'b00};
    assign w_tvec_full = (r_mtvec_mode && ex_irq)
                       ? (w_tvec_base + {26'b0, ex_cause, 2'b00})
                       : w_tvec_base;
    assign ex_tvec = w_tvec_full[31:1];
    assign ret_epc = r_mepc;
    assign mie_out = r_mie;

    // mstatus: trap entry beats MRET beats a CSR write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie  <= 1'b0;
            r_mpie <= 1'b0;
        end else if (w_take_trap) begin
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
        end else if (w_take_ret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
            r_mie  <= w_wdata[3];
            r_mpie <= w_wdata[7];
        end
    end

    // mepc/mcause: trap entry overrides a same-cycle CSR write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mepc        <= '0;
            r_mcause_irq  <= 1'b0;
            r_mcause_code <= '0;
        end else if (w_take_trap) begin
            r_mepc        <= ex_epc;
            r_mcause_irq  <= ex_irq;
            r_mcause_code <= ex_cause;
        end else begin
            if (w_wr_mepc) begin
                r_mepc <= w_wdata[31:1];
            end
            if (w_wr_mcause) begin
                r_mcause_irq  <= w_wdata[31];
                r_mcause_code <= w_wdata[3:0];
            end
        end
    end

    // mtvec and mscratch: plain CSR-write registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtvec_base <= '0;
            r_mtvec_mode <= 1'b0;
            r_mscratch   <= '0;
        end else begin
            if (w_wr_mtvec) begin
                r_mtvec_base <= w_wdata[31:2];
                r_mtvec_mode <= w_wdata[0];
            end
            if (w_wr_mscratch) begin
                r_mscratch <= w_wdata;
            end
        end
    end

    // Cycle counter; a write to either half suppresses that cycle's increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle <= '0;
        end else if (w_wr_mcycle_lo) begin
            r_mcycle[31:0] <= w_wdata;
        end else if (w_wr_mcycle_hi) begin
            r_mcycle[63:32] <= w_wdata;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    // Retired-instruction counter; a write wins over the instret pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_minstret <= '0;
        end else if (w_wr_minstret_lo) begin
            r_minstret[31:0] <= w_wdata;
        end else if (w_wr_minstret_hi) begin
            r_minstret[63:32] <= w_wdata;
        end else if (instret) begin
            r_minstret <= r_minstret + 64'd1;
        end
    end

endmodule
